// File: rtl/audio_pll_lock_sequencer.sv
// Audio PLL reset and lock supervisor, refclk domain.
// Pulses the PLL reset and waits for lock with a timeout. Lock must then stay
// stable before the audio-domain reset is released. Failed attempts are retried
// a bounded number of times before the block parks in FAULT.
module audio_pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES   = 10,
    parameter int unsigned LOCK_TIMEOUT       = 50000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned CNT_W              = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       audio_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sync_q;
    logic               lock_s;
    logic [3:0]         retry_inc;
    logic               attempt_fail;

    assign retry_inc = retry_cnt + 4'd1;

    // An attempt fails on lock timeout (lock wins a tie) or on any lock drop while stable.
    assign attempt_fail = ((state == S_WAIT_LOCK) && !lock_s && (cnt == TIMEOUT_LAST)) ||
                          ((state == S_STABLE) && !lock_s);

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lock_s <= sync_q;
        end
    end

    // Sequencer state, shared cycle counter and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_RESET;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            audio_rst     <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else if (relock_req && (state != S_RESET)) begin
            state     <= S_RESET;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            audio_rst <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
        end else if (attempt_fail) begin
            cnt       <= '0;
            retry_cnt <= retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
                state   <= S_FAULT;
                pll_rst <= 1'b0;
                fault   <= 1'b1;
            end else begin
                state   <= S_RESET;
                pll_rst <= 1'b1;
            end
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (cnt == STABLE_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        audio_rst <= 1'b0;
                        ready     <= 1'b1;
                        retry_cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state     <= S_RESET;
                        cnt       <= '0;
                        pll_rst   <= 1'b1;
                        audio_rst <= 1'b1;
                        ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    cnt <= '0;
                end
                default: begin
                    state     <= S_RESET;
                    cnt       <= '0;
                    pll_rst   <= 1'b1;
                    audio_rst <= 1'b1;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_pll_lock_sequencer.sv
// Directed bench for audio_pll_lock_sequencer with short timing parameters.
// Cycle k is the interval after the (k-1)th rising edge; inputs are set and
// outputs sampled on the falling edge inside that interval.
module tb_audio_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       audio_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    audio_pll_lock_sequencer #(
        .RST_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT      (20),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (3),
        .CNT_W             (20)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .audio_rst    (audio_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge refclk);
            cyc++;
        end
    endtask

    task automatic goto(input int n);
        if (n > cyc) adv(n - cyc);
    endtask

    // Apply one reset edge; returns positioned in cycle 0 with rst released.
    task automatic do_reset();
        @(negedge refclk);
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pll_rst"}, 8'(pll_rst), 8'd1);
        chk({tag, ".audio_rst"}, 8'(audio_rst), 8'd1);
        chk({tag, ".ready"}, 8'(ready), 8'd0);
        chk({tag, ".fault"}, 8'(fault), 8'd0);
        chk({tag, ".retry"}, 8'(retry_cnt), 8'd0);
        chk({tag, ".lls"}, lock_loss_cnt, 8'd0);
    endtask

    initial begin
        int pulses;

        // Nominal lock
        do_reset();
        chk_reset_vals("nom_reset");
        goto(3);  chk("nom_pll_rst_c3", 8'(pll_rst), 8'd1);
        goto(4);  chk("nom_pll_rst_c4", 8'(pll_rst), 8'd0);
        goto(10); pll_locked = 1'b1;
        goto(20); chk("nom_ready_c20", 8'(ready), 8'd0);
                  chk("nom_arst_c20", 8'(audio_rst), 8'd1);
        goto(21); chk("nom_ready_c21", 8'(ready), 8'd1);
                  chk("nom_arst_c21", 8'(audio_rst), 8'd0);
                  chk("nom_retry_c21", 8'(retry_cnt), 8'd0);
                  chk("nom_fault_c21", 8'(fault), 8'd0);

        // Lock loss in RUN, then re-lock
        goto(40); pll_locked = 1'b0;
        goto(42); chk("loss_ready_c42", 8'(ready), 8'd1);
        goto(43); chk("loss_ready_c43", 8'(ready), 8'd0);
                  chk("loss_arst_c43", 8'(audio_rst), 8'd1);
                  chk("loss_pll_rst_c43", 8'(pll_rst), 8'd1);
                  chk("loss_lls_c43", lock_loss_cnt, 8'd1);
                  chk("loss_retry_c43", 8'(retry_cnt), 8'd0);
                  pll_locked = 1'b1;
        goto(47); chk("loss_pll_rst_c47", 8'(pll_rst), 8'd0);
        goto(55); chk("loss_ready_c55", 8'(ready), 8'd0);
        goto(56); chk("loss_ready_c56", 8'(ready), 8'd1);
                  chk("loss_lls_c56", lock_loss_cnt, 8'd1);

        // Never locks: three timed-out attempts end in FAULT
        do_reset();
        goto(23); chk("nl_retry_c23", 8'(retry_cnt), 8'd0);
                  chk("nl_pll_rst_c23", 8'(pll_rst), 8'd0);
        goto(24); chk("nl_retry_c24", 8'(retry_cnt), 8'd1);
                  chk("nl_pll_rst_c24", 8'(pll_rst), 8'd1);
        goto(48); chk("nl_retry_c48", 8'(retry_cnt), 8'd2);
        goto(71); chk("nl_fault_c71", 8'(fault), 8'd0);
        goto(72); chk("nl_fault_c72", 8'(fault), 8'd1);
                  chk("nl_retry_c72", 8'(retry_cnt), 8'd3);
                  chk("nl_pll_rst_c72", 8'(pll_rst), 8'd0);
                  chk("nl_arst_c72", 8'(audio_rst), 8'd1);
                  chk("nl_ready_c72", 8'(ready), 8'd0);
        pulses = 0;
        repeat (28) begin
            adv(1);
            if (pll_rst) pulses++;
        end
        chk("nl_no_pulses", 8'(pulses), 8'd0);
        chk("nl_fault_held", 8'(fault), 8'd1);
        chk("nl_retry_held", 8'(retry_cnt), 8'd3);

        // Relock from FAULT; relock_req during RESET is ignored
        goto(100); relock_req = 1'b1;
        goto(101); relock_req = 1'b0;
                   chk("rl_fault_c101", 8'(fault), 8'd0);
                   chk("rl_retry_c101", 8'(retry_cnt), 8'd0);
                   chk("rl_pll_rst_c101", 8'(pll_rst), 8'd1);
        goto(102); relock_req = 1'b1;
        goto(103); relock_req = 1'b0;
        goto(104); chk("rl_pll_rst_c104", 8'(pll_rst), 8'd1);
        goto(105); chk("rl_pll_rst_c105", 8'(pll_rst), 8'd0);

        // Glitch during STABLE forces a retry and a full fresh stable window
        do_reset();
        goto(10); pll_locked = 1'b1;
        goto(15); pll_locked = 1'b0;
        goto(16); pll_locked = 1'b1;
        goto(17); chk("gl_pll_rst_c17", 8'(pll_rst), 8'd0);
                  chk("gl_retry_c17", 8'(retry_cnt), 8'd0);
        goto(18); chk("gl_pll_rst_c18", 8'(pll_rst), 8'd1);
                  chk("gl_retry_c18", 8'(retry_cnt), 8'd1);
        goto(21); chk("gl_ready_c21", 8'(ready), 8'd0);
        goto(22); chk("gl_pll_rst_c22", 8'(pll_rst), 8'd0);
        goto(30); chk("gl_ready_c30", 8'(ready), 8'd0);
        goto(31); chk("gl_ready_c31", 8'(ready), 8'd1);
                  chk("gl_retry_c31", 8'(retry_cnt), 8'd0);

        // Lock saturation: 256 lock losses, each re-locking to RUN 16 cycles later
        for (int i = 1; i <= 256; i++) begin
            pll_locked = 1'b0;
            adv(3);
            pll_locked = 1'b1;
            adv(13);
            if (i == 10) chk("sat_lls_10", lock_loss_cnt, 8'd10);
        end
        chk("sat_lls_256", lock_loss_cnt, 8'd255);
        chk("sat_ready", 8'(ready), 8'd1);

        // Synchronous reset in RUN clears everything on the next edge
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk_reset_vals("rst_run");

        // Lock arriving on the timeout cycle wins over the timeout
        do_reset();
        goto(21); pll_locked = 1'b1;
        goto(24); chk("tie_pll_rst_c24", 8'(pll_rst), 8'd0);
                  chk("tie_retry_c24", 8'(retry_cnt), 8'd0);
        goto(31); chk("tie_ready_c31", 8'(ready), 8'd0);
        goto(32); chk("tie_ready_c32", 8'(ready), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_pll_lock_sequencer.md
Name: audio_pll_lock_sequencer

Overview:
- Reset and lock supervisor for the audio subsystem PLL (50 MHz refclk to 12.288 MHz audio clock).
- Pulses the PLL reset, waits for lock with a timeout, and requires lock to stay stable before releasing the audio-domain reset.
- Retries a bounded number of times, then reports a fault. Runs entirely in the refclk domain.

Parameters:
- RST_PULSE_CYCLES, 10, refclk cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before the attempt fails (>=1)
- LOCK_STABLE_CYCLES, 1024, consecutive cycles synchronized lock must be high before RUN (>=1)
- MAX_RETRIES, 3, failed attempts that send the block to FAULT (1..15)
- CNT_W, 20, width of the shared cycle counter; must hold max(params)-1

Ports:
- refclk  in  1  50 MHz reference clock; the block's only clock
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL locked output; asynchronous, synchronized internally
- relock_req  in  1  single-cycle software request to restart the sequence
- pll_rst  out  1  reset to the PLL
- audio_rst  out  1  reset for audio-clock-domain logic; high until RUN
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- retry_cnt  out  4  failed attempts since the last RUN entry or restart
- lock_loss_cnt  out  8  saturating count of RUN-to-RESET transitions

Behaviour:
- One clock (refclk); reset is synchronous and active-high on rst. All outputs are registered and update on the same edge as the state change.
- Reset values: state=RESET, cnt=0, pll_rst=1, audio_rst=1, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchronizer flops=0.
- pll_locked passes through a 2-flop synchronizer to produce lock_s, giving 2 cycles of latency.
- cnt clears on every state entry.
- RESET: pll_rst=1. Stays RESET while cnt<RST_PULSE_CYCLES-1; at cnt==RST_PULSE_CYCLES-1 goes to WAIT_LOCK. After rst is released, pll_rst is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0.
  - lock_s=1 goes to STABLE.
  - Otherwise, cnt==LOCK_TIMEOUT-1 is a failure.
  - If lock and timeout occur in the same cycle, lock wins.
- STABLE:
  - lock_s=0 on any cycle is a failure.
  - lock_s=1 with cnt==LOCK_STABLE_CYCLES-1 goes to RUN.
- RUN: audio_rst=0, ready=1, retry_cnt cleared on entry. lock_s=0 goes to RESET and increments lock_loss_cnt, saturating at 255. retry_cnt is not incremented.
- Failure handling: retry_cnt increments by 1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET.
- FAULT: pll_rst=0, audio_rst=1, fault=1, retry_cnt held. The block leaves FAULT only on relock_req or rst.
- relock_req=1 in any state except RESET: next state is RESET, cnt=0, retry_cnt=0. relock_req in RESET is ignored. relock_req has priority over lock/timeout decisions in the same cycle.
- rst asserted mid-operation: all registers return to their reset values on the next edge, including lock_loss_cnt.
- audio_rst=1 in every state except RUN.
- ready and fault are never high together.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3. Cycle 0 is the first edge with rst=0.
- Nominal lock: pll_locked rises at cycle 10 and holds -> pll_rst=1 for cycles 0-3, WAIT_LOCK from 4, STABLE at 13, ready=1 and audio_rst=0 at 21, retry_cnt=0.
- Never locks: pll_locked=0 throughout -> three 24-cycle attempts; retry_cnt reads 1 at 24 and 2 at 48; fault=1 with retry_cnt=3 at 72; pll_rst=0 thereafter; no further pll_rst pulses.
- Lock loss in RUN: from nominal, drop pll_locked at cycle 40 -> ready=0, audio_rst=1 and pll_rst=1 at 43; lock_loss_cnt=1; re-lock reaches RUN again.
- Glitch during STABLE: pll_locked low for 1 cycle at cycle 15 -> STABLE is exited, retry_cnt=1, pll_rst reasserts, RUN is not entered until a full 8-cycle stable window.
- Relock from FAULT: pulse relock_req in FAULT -> RESET next cycle, fault=0, retry_cnt=0, pll_rst high for 4 cycles. relock_req pulsed during RESET has no effect.
- Reset mid-RUN, plus saturation: force 256 lock losses -> lock_loss_cnt stays 255. Then assert rst for 1 cycle in RUN -> all outputs at reset values on the next edge, lock_loss_cnt=0.
